// File: rtl/filter_uart_pkg.sv
// Shared definitions for the filter-sample UART transmitter.
// Holds the FSM state encoding, the data width and the frame lengths
// for both parity modes (FILTER_UART_PARITY_EN selects 8E1, otherwise 8N1).
package filter_uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned DATA_BITS      = 8;
    localparam int unsigned FRAME_BITS_8N1 = 10;
    localparam int unsigned FRAME_BITS_8E1 = 11;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push, wr_data    write request and data (ignored while full)
//   pop, rd_data     read request (ignored while empty) and head entry
//   full, empty      derived from level
//   level            occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sample_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/filter_sample_uart_tx.sv
// Output stage of the digital filter: buffers 8-bit samples and sends each
// one as a UART frame, LSB first.
// Optional feature macro: FILTER_UART_PARITY_EN (adds an even-parity bit, 8E1);
// when undefined the frame is 8N1 and no parity logic exists.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ena               allow new frames to start (current frame always completes)
//   s_data, s_valid   sample input, accepted when s_valid && s_ready
//   s_ready           FIFO not full (low during reset)
//   tx                registered serial line, idle high
//   busy              frame on the line or samples queued
//   level             FIFO occupancy
module filter_sample_uart_tx
    import filter_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    input  logic [7:0]                  s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int unsigned   TW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT   = 3'(DATA_BITS - 1);

    uart_state_e          state;
    uart_state_e          state_d;
    logic [TW-1:0]        timer;
    logic [TW-1:0]        timer_d;
    logic [2:0]           bit_idx;
    logic [2:0]           bit_idx_d;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_d;
    logic                 tx_d;
    logic                 ready_en;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [DATA_BITS-1:0] head;
    logic                 bit_done;
    logic                 frame_ready;

    assign bit_done    = (timer == TIMER_LAST);
    assign frame_ready = ena && !empty;
    assign s_ready     = ready_en && !full;
    assign push        = s_valid && s_ready;
    assign busy        = (state != S_IDLE) || (level != '0);

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .wr_data (s_data),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    // Holds s_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_d;
            timer   <= timer_d;
            bit_idx <= bit_idx_d;
            shift   <= shift_d;
            tx      <= tx_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (frame_ready) state_d = S_START;
            S_START: if (bit_done) state_d = S_DATA;
            S_DATA: begin
                if (bit_done && (bit_idx == LAST_BIT)) begin
`ifdef FILTER_UART_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef FILTER_UART_PARITY_EN
            S_PARITY: if (bit_done) state_d = S_STOP;
`endif
            S_STOP:  if (bit_done) state_d = frame_ready ? S_START : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // tx is driven from the next state so the line changes on the same edge
    // as the state register, giving a one-cycle pop-to-start-bit latency.
    always_comb begin
        pop       = frame_ready && ((state == S_IDLE) || ((state == S_STOP) && bit_done));
        shift_d   = pop ? head : shift;
        timer_d   = ((state == S_IDLE) || bit_done) ? '0 : timer + TW'(1);
        bit_idx_d = (state != S_DATA) ? '0 : (bit_done ? bit_idx + 3'd1 : bit_idx);
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[bit_idx_d];
`ifdef FILTER_UART_PARITY_EN
            S_PARITY: tx_d = ^shift_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_filter_sample_uart_tx.sv
module tb_filter_sample_uart_tx;

    localparam int C = 4;
`ifdef FILTER_UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic       tx;
    logic       busy;
    logic [2:0] level;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] model_q[$];

    filter_sample_uart_tx #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .tx      (tx),
        .busy    (busy),
        .level   (level)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    // Line value for bit slot i of the frame carrying d.
    function automatic logic frame_bit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
`ifdef FILTER_UART_PARITY_EN
        if (i == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_sample(input logic [7:0] d);
        int w = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 1000) begin
            n_cmp++;
            n_err++;
            $display("FAIL push_timeout s_ready=%b required 1", s_ready);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_q.push_back(d);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Checks every cycle of one frame; ends at the negedge after the stop bit.
    task automatic check_frame(input bit allow_wait, input int drop_at, input string tag);
        logic [7:0] d;
        int w = 0;
        if (allow_wait) begin
            while (tx === 1'b1 && w < 2000) begin
                @(negedge clk);
                w++;
            end
        end
        n_cmp++;
        if (tx !== 1'b0) begin
            n_err++;
            $display("FAIL %s_start tx=%b required 0", tag, tx);
            return;
        end
        n_cmp++;
        if (model_q.size() == 0) begin
            n_err++;
            $display("FAIL %s_unexpected_frame queued=0 required >=1", tag);
            return;
        end
        d = model_q.pop_front();
        n_cmp++;
        if (level !== 3'(model_q.size())) begin
            n_err++;
            $display("FAIL %s_level level=%0d required %0d", tag, level, model_q.size());
        end
        for (int i = 0; i < NBITS; i++) begin
            for (int k = 0; k < C; k++) begin
                if (i * C + k == drop_at) ena = 1'b0;
                n_cmp++;
                if (tx !== frame_bit(d, i)) begin
                    n_err++;
                    $display("FAIL %s_bit%0d_cyc%0d data=%02h tx=%b required %b",
                             tag, i, k, d, tx, frame_bit(d, i));
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #16;
        n_cmp++; if (tx !== 1'b1)      begin n_err++; $display("FAIL rst_tx tx=%b required 1", tx); end
        n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL rst_busy busy=%b required 0", busy); end
        n_cmp++; if (level !== 3'd0)   begin n_err++; $display("FAIL rst_level level=%0d required 0", level); end
        n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready s_ready=%b required 0", s_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL rel_ready_early s_ready=%b required 0", s_ready); end
        @(negedge clk);
        n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL rel_ready s_ready=%b required 1", s_ready); end
    endtask

    task automatic test_single();
        ena = 1'b1;
        push_sample(8'hA5);
        n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL single_pre tx=%b required 1", tx); end
        @(negedge clk);
        check_frame(1'b0, -1, "single");
        n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL single_busy busy=%b required 0", busy); end
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL single_level level=%0d required 0", level); end
    endtask

    task automatic test_back_to_back();
        bit saw_full = 1'b0;
        ena = 1'b1;
        fork
            begin
                for (int i = 1; i <= 6; i++) push_sample(8'(i));
            end
            begin
                check_frame(1'b1, -1, "b2b");
                for (int i = 0; i < 5; i++) check_frame(1'b0, -1, "b2b");
            end
            begin
                for (int c = 0; c < 300; c++) begin
                    n_cmp++;
                    if (s_ready !== (level != 3'd4)) begin
                        n_err++;
                        $display("FAIL b2b_ready s_ready=%b required %b (level=%0d)", s_ready, level != 3'd4, level);
                    end
                    if (level == 3'd4) saw_full = 1'b1;
                    @(negedge clk);
                end
            end
        join
        n_cmp++; if (!saw_full)     begin n_err++; $display("FAIL b2b_full_seen seen=0 required 1"); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy busy=%b required 0", busy); end
    endtask

    task automatic test_ena_hold();
        ena = 1'b0;
        push_sample(8'($urandom));
        push_sample(8'($urandom));
        for (int c = 0; c < 20; c++) begin
            n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL hold_idle tx=%b required 1", tx); end
            @(negedge clk);
        end
        n_cmp++; if (level !== 3'd2) begin n_err++; $display("FAIL hold_level level=%0d required 2", level); end
        n_cmp++; if (busy !== 1'b1)  begin n_err++; $display("FAIL hold_busy busy=%b required 1", busy); end
        ena = 1'b1;
        @(negedge clk);
        check_frame(1'b0, -1, "hold");
        check_frame(1'b0, -1, "hold2");
    endtask

    task automatic test_ena_drop();
        ena = 1'b1;
        push_sample(8'h3C);
        push_sample(8'($urandom));
        check_frame(1'b1, 4 * C + 1, "drop");
        for (int c = 0; c < 2 * NBITS * C; c++) begin
            n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL drop_held tx=%b required 1", tx); end
            @(negedge clk);
        end
        n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL drop_level level=%0d required 1", level); end
        n_cmp++; if (busy !== 1'b1)  begin n_err++; $display("FAIL drop_busy busy=%b required 1", busy); end
        ena = 1'b1;
        @(negedge clk);
        check_frame(1'b0, -1, "drop_resume");
    endtask

    task automatic test_reset_mid();
        logic [7:0] d0;
        d0  = 8'($urandom);
        ena = 1'b1;
        push_sample(d0);
        for (int i = 0; i < 3; i++) push_sample(8'($urandom));
        // frame began two negedges ago; move to the middle of data bit 5
        repeat (6 * C - 1) @(negedge clk);
        n_cmp++; if (level !== 3'd3) begin n_err++; $display("FAIL mid_level level=%0d required 3", level); end
        n_cmp++; if (tx !== d0[5])   begin n_err++; $display("FAIL mid_bit5 tx=%b required %b", tx, d0[5]); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (tx !== 1'b1)    begin n_err++; $display("FAIL abort_tx tx=%b required 1", tx); end
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL abort_level level=%0d required 0", level); end
        n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL abort_busy busy=%b required 0", busy); end
        model_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_sample(8'h55);
        n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL post_rst_pre tx=%b required 1", tx); end
        @(negedge clk);
        check_frame(1'b0, -1, "post_rst");
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_rst_busy busy=%b required 0", busy); end
    endtask

    task automatic test_random();
        ena = 1'b1;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    repeat ($urandom_range(0, 60)) @(negedge clk);
                    push_sample(8'($urandom));
                end
            end
            begin
                for (int i = 0; i < 16; i++) check_frame(1'b1, -1, "rand");
            end
        join
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rand_busy busy=%b required 0", busy); end
    endtask

`ifdef FILTER_UART_PARITY_EN
    task automatic test_parity();
        ena = 1'b1;
        push_sample(8'h07);
        @(negedge clk);
        check_frame(1'b0, -1, "par07");
        push_sample(8'h03);
        @(negedge clk);
        check_frame(1'b0, -1, "par03");
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ena_hold();
        test_ena_drop();
        test_reset_mid();
        test_random();
`ifdef FILTER_UART_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
